// File: rtl/bp_pkg.sv
// Shared types, counter encodings and saturating helpers for the RV32 branch predictor.
package bp_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_MAX_W = 30;
  localparam int unsigned CNT_W     = 2;

  localparam logic [CNT_W-1:0] SNT = 2'b00;
  localparam logic [CNT_W-1:0] WNT = 2'b01;
  localparam logic [CNT_W-1:0] WT  = 2'b10;
  localparam logic [CNT_W-1:0] ST  = 2'b11;

  // Tag is stored zero-extended to the widest legal tag so the struct stays unparameterised.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [XLEN-1:0]      target;
    logic [CNT_W-1:0]     cnt;
  } btb_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc2(input logic [CNT_W-1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec2(input logic [CNT_W-1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  function automatic logic [XLEN-1:0] sat_inc32(input logic [XLEN-1:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

endpackage

// File: rtl/rv32_branch_predictor_if.sv
// Pipeline-side bundle of the branch predictor: IF lookup, ID resolve and status outputs.
interface rv32_branch_predictor_if;
  import bp_pkg::*;

  logic [XLEN-1:0] pc_if;
  logic            pred_taken_if;
  logic [XLEN-1:0] pred_target_if;
  logic            fd_en;
  logic            fd_flush_in;
  logic            id_valid;
  logic            id_fire;
  logic [XLEN-1:0] pc_id;
  logic            id_is_branch;
  logic            id_is_jump;
  logic            id_taken;
  logic [XLEN-1:0] id_target;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_fd;
  logic [XLEN-1:0] ctrl_cnt;
  logic [XLEN-1:0] miss_cnt;

  modport master (
    output pc_if, fd_en, fd_flush_in, id_valid, id_fire, pc_id,
           id_is_branch, id_is_jump, id_taken, id_target,
    input  pred_taken_if, pred_target_if, redirect, redirect_pc,
           flush_fd, ctrl_cnt, miss_cnt
  );

  modport slave (
    input  pc_if, fd_en, fd_flush_in, id_valid, id_fire, pc_id,
           id_is_branch, id_is_jump, id_taken, id_target,
    output pred_taken_if, pred_target_if, redirect, redirect_pc,
           flush_fd, ctrl_cnt, miss_cnt
  );
endinterface

// File: rtl/bp_btb_table.sv
// Direct-mapped BTB storage: async read port for IF, read-modify-write port for ID training.
module bp_btb_table
  import bp_pkg::*;
#(
  parameter  int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output btb_entry_t       rd_entry_o,
  input  logic [IDX_W-1:0] upd_idx_i,
  output btb_entry_t       upd_entry_o,
  input  logic             upd_we_i,
  input  btb_entry_t       upd_wdata_i
);

  btb_entry_t mem_q [ENTRIES];

  assign rd_entry_o  = mem_q[rd_idx_i];
  assign upd_entry_o = mem_q[upd_idx_i];

  // Reset leaves every slot invalid with a weakly-not-taken counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
      end
    end else if (upd_we_i) begin
      mem_q[upd_idx_i] <= upd_wdata_i;
    end
  end

endmodule

// File: rtl/rv32_branch_predictor.sv
// Branch prediction unit: IF lookup, ID prediction register, mispredict redirect, training and counters.
module rv32_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8
) (
  input logic                    clk,
  input logic                    rst,
  rv32_branch_predictor_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] idx_if, idx_id;
  logic [TAG_W-1:0] tag_if, tag_id;
  btb_entry_t       rd_entry, upd_entry, wr_entry;
  logic             wr_en;
  logic             hit_if, hit_id, pred_taken_if;
  logic             act, is_ctrl, upd_fire, redirect;

  logic            pred_taken_q, pred_taken_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;
  logic [XLEN-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [XLEN-1:0] miss_cnt_q, miss_cnt_d;

  assign idx_if = bus.pc_if[IDX_W+1:2];
  assign tag_if = bus.pc_if[IDX_W+TAG_W+1:IDX_W+2];
  assign idx_id = bus.pc_id[IDX_W+1:2];
  assign tag_id = bus.pc_id[IDX_W+TAG_W+1:IDX_W+2];

  bp_btb_table #(.ENTRIES(ENTRIES)) u_table (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (idx_if),
    .rd_entry_o (rd_entry),
    .upd_idx_i  (idx_id),
    .upd_entry_o(upd_entry),
    .upd_we_i   (wr_en),
    .upd_wdata_i(wr_entry)
  );

  assign hit_if             = rd_entry.valid && (rd_entry.tag == TAG_MAX_W'(tag_if));
  assign pred_taken_if      = hit_if && rd_entry.cnt[1];
  assign bus.pred_taken_if  = pred_taken_if;
  assign bus.pred_target_if = pred_taken_if ? rd_entry.target : bus.pc_if + 32'd4;

  // An aliased non-control instruction predicted taken must fall through to pc_id+4.
  assign act      = bus.id_is_jump || (bus.id_is_branch && bus.id_taken);
  assign is_ctrl  = bus.id_is_jump || bus.id_is_branch;
  assign redirect = bus.id_valid &&
                    (act ? (!pred_taken_q || (pred_target_q != bus.id_target)) : pred_taken_q);

  assign bus.redirect    = redirect;
  assign bus.flush_fd    = redirect;
  assign bus.redirect_pc = act ? bus.id_target : bus.pc_id + 32'd4;
  assign bus.ctrl_cnt    = ctrl_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;

  assign upd_fire = bus.id_fire && bus.id_valid;
  assign hit_id   = upd_entry.valid && (upd_entry.tag == TAG_MAX_W'(tag_id));

  // Training write for the instruction leaving ID.
  always_comb begin
    wr_entry = upd_entry;
    wr_en    = 1'b0;
    if (upd_fire) begin
      if (is_ctrl && hit_id) begin
        wr_en = 1'b1;
        if (bus.id_is_jump) wr_entry.cnt = ST;
        else if (bus.id_taken) wr_entry.cnt = sat_inc2(upd_entry.cnt);
        else wr_entry.cnt = sat_dec2(upd_entry.cnt);
        if (act) wr_entry.target = bus.id_target;
      end else if (is_ctrl && act) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: TAG_MAX_W'(tag_id), target: bus.id_target,
                     cnt: bus.id_is_jump ? ST : WT};
      end else if (!is_ctrl && hit_id) begin
        wr_en          = 1'b1;
        wr_entry.valid = 1'b0;
      end
    end
  end

  always_comb begin
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    ctrl_cnt_d    = ctrl_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    if (bus.fd_flush_in || redirect) begin
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
    end else if (bus.fd_en) begin
      pred_taken_d  = pred_taken_if;
      pred_target_d = bus.pred_target_if;
    end
    if (upd_fire && is_ctrl)  ctrl_cnt_d = sat_inc32(ctrl_cnt_q);
    if (upd_fire && redirect) miss_cnt_d = sat_inc32(miss_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      ctrl_cnt_q    <= '0;
      miss_cnt_q    <= '0;
    end else begin
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      ctrl_cnt_q    <= ctrl_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Directed scenarios plus randomized traffic checked against a table-level reference model.
module tb_rv32_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32_branch_predictor_if bus ();

  rv32_branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model state
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  bit          m_pt;
  logic [31:0] m_ptg;
  longint      m_ctrl, m_miss;

  bit          e_pt_if, e_redir;
  logic [31:0] e_ptg_if, e_rpc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (2 ** TAG_W);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_pt = 0; m_ptg = 0; m_ctrl = 0; m_miss = 0;
  endtask

  task automatic model_eval();
    int unsigned i;
    bit act;
    i        = idx_of(bus.pc_if);
    e_pt_if  = m_valid[i] && (m_tag[i] == tag_of(bus.pc_if)) && (m_cnt[i] >= 2);
    e_ptg_if = e_pt_if ? m_tgt[i] : bus.pc_if + 32'd4;
    act      = bus.id_is_jump || (bus.id_is_branch && bus.id_taken);
    e_redir  = bus.id_valid && (act ? (!m_pt || m_ptg != bus.id_target) : m_pt);
    e_rpc    = act ? bus.id_target : bus.pc_id + 32'd4;
  endtask

  task automatic model_update();
    int unsigned i;
    bit hit, ctrl, act;
    if (bus.id_fire && bus.id_valid) begin
      i    = idx_of(bus.pc_id);
      hit  = m_valid[i] && (m_tag[i] == tag_of(bus.pc_id));
      ctrl = bus.id_is_branch || bus.id_is_jump;
      act  = bus.id_is_jump || (bus.id_is_branch && bus.id_taken);
      if (ctrl && hit) begin
        if (bus.id_is_jump) m_cnt[i] = 3;
        else if (bus.id_taken) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        else m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        if (act) m_tgt[i] = bus.id_target;
      end else if (ctrl && act) begin
        m_valid[i] = 1; m_tag[i] = tag_of(bus.pc_id); m_tgt[i] = bus.id_target;
        m_cnt[i] = bus.id_is_jump ? 3 : 2;
      end else if (!ctrl && hit) begin
        m_valid[i] = 0;
      end
      if (ctrl && m_ctrl < 64'hFFFF_FFFF) m_ctrl++;
      if (e_redir && m_miss < 64'hFFFF_FFFF) m_miss++;
    end
    if (bus.fd_flush_in || e_redir) begin
      m_pt = 0; m_ptg = 0;
    end else if (bus.fd_en) begin
      m_pt = e_pt_if; m_ptg = e_ptg_if;
    end
  endtask

  task automatic check_outputs();
    chk("pred_taken_if", 32'(bus.pred_taken_if), 32'(e_pt_if));
    chk("pred_target_if", bus.pred_target_if, e_ptg_if);
    chk("redirect", 32'(bus.redirect), 32'(e_redir));
    chk("flush_fd", 32'(bus.flush_fd), 32'(e_redir));
    if (e_redir) chk("redirect_pc", bus.redirect_pc, e_rpc);
    chk("ctrl_cnt", bus.ctrl_cnt, 32'(m_ctrl));
    chk("miss_cnt", bus.miss_cnt, 32'(m_miss));
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_if(input logic [31:0] pc, input bit en, input bit flush);
    bus.pc_if = pc; bus.fd_en = en; bus.fd_flush_in = flush;
  endtask

  task automatic set_id(input bit v, input bit fire, input logic [31:0] pc,
                        input bit br, input bit jmp, input bit tk, input logic [31:0] tgt);
    bus.id_valid = v; bus.id_fire = fire; bus.pc_id = pc;
    bus.id_is_branch = br; bus.id_is_jump = jmp; bus.id_taken = tk; bus.id_target = tgt;
  endtask

  logic [31:0] pc_pool  [8] = '{32'h100, 32'h104, 32'h140, 32'h200, 32'h240, 32'h300, 32'h108, 32'h10C};
  logic [31:0] tgt_pool [5] = '{32'h80, 32'h40, 32'h500, 32'h104, 32'h204};

  initial begin
    rst = 1'b1;
    set_if(32'h100, 1'b0, 1'b0);
    set_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    model_reset();
    model_eval();
    check_outputs();
    chk("rst_pred_target", bus.pred_target_if, 32'h104);
    @(posedge clk); #1;
    rst = 1'b0;

    // Lookup of an empty table, loading a not-taken prediction into ID
    set_if(32'h100, 1'b1, 1'b0);
    sample();
    chk("empty_pred_taken", 32'(bus.pred_taken_if), 32'h0);
    chk("empty_ctrl_cnt", bus.ctrl_cnt, 32'h0);
    advance();

    // BEQ 0x100 taken to 0x80: first fire mispredicts and allocates
    set_if(32'h80, 1'b1, 1'b0);
    set_id(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
    sample();
    chk("beq1_redirect", 32'(bus.redirect), 32'h1);
    chk("beq1_redirect_pc", bus.redirect_pc, 32'h80);
    advance();
    set_if(32'h100, 1'b1, 1'b0);
    set_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("beq1_miss_cnt", bus.miss_cnt, 32'h1);
    chk("beq2_pred_taken", 32'(bus.pred_taken_if), 32'h1);
    chk("beq2_pred_target", bus.pred_target_if, 32'h80);
    advance();
    set_if(32'h100, 1'b1, 1'b0);
    set_id(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
    sample();
    chk("beq2_no_redirect", 32'(bus.redirect), 32'h0);
    advance();

    // Same branch now not taken with a strong counter
    set_if(32'h104, 1'b1, 1'b0);
    set_id(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80);
    sample();
    chk("beqnt_redirect", 32'(bus.redirect), 32'h1);
    chk("beqnt_redirect_pc", bus.redirect_pc, 32'h104);
    advance();
    set_if(32'h100, 1'b0, 1'b0);
    set_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("beqnt_still_taken", 32'(bus.pred_taken_if), 32'h1);
    advance();

    // JAL 0x200 -> 0x40, then an index alias with a different tag
    set_if(32'h40, 1'b0, 1'b0);
    set_id(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h40);
    sample(); advance();
    set_if(32'h200 + 4 * ENTRIES, 1'b1, 1'b0);
    set_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("alias_miss", 32'(bus.pred_taken_if), 32'h0);
    advance();
    set_if(32'h200, 1'b1, 1'b0);
    set_id(1'b1, 1'b1, 32'h200 + 4 * ENTRIES, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("jal_retained", bus.pred_target_if, 32'h40);
    advance();
    set_if(32'h204, 1'b1, 1'b0);
    set_id(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("alias_hit_redirect", 32'(bus.redirect), 32'h1);
    chk("alias_hit_pc", bus.redirect_pc, 32'h204);
    advance();
    set_if(32'h200, 1'b0, 1'b0);
    set_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("alias_cleared", 32'(bus.pred_taken_if), 32'h0);
    advance();

    // ID stall during a mispredict: redirect held, one update on the fire cycle
    set_if(32'h304, 1'b0, 1'b0);
    set_id(1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 1'b1, 32'h500);
    for (int s = 0; s < 3; s++) begin
      sample();
      chk("stall_redirect", 32'(bus.redirect), 32'h1);
      advance();
    end
    bus.id_fire = 1'b1;
    sample(); advance();
    set_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_if(32'h300, 1'b1, 1'b0);
    sample();
    chk("stall_trained", bus.pred_target_if, 32'h500);
    advance();

    // fd_flush_in beats fd_en and clears the ID prediction
    set_if(32'h300, 1'b1, 1'b1);
    sample(); advance();
    set_if(32'h0, 1'b0, 1'b0);
    set_id(1'b1, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk("flush_cleared", 32'(bus.redirect), 32'h0);
    advance();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned k;
      k = $urandom_range(0, 3);
      set_if(pc_pool[$urandom_range(0, 7)], ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      set_id(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), pc_pool[$urandom_range(0, 7)],
             (k == 1 || k == 2), (k == 3), $urandom_range(0, 1) == 1, tgt_pool[$urandom_range(0, 4)]);
      sample(); advance();
    end

    // Train five jumps, then reset in the middle of a training cycle
    for (int j = 0; j < 5; j++) begin
      set_if(32'h0, 1'b0, 1'b0);
      set_id(1'b1, 1'b1, 32'h400 + 32'(4 * j), 1'b0, 1'b1, 1'b1, 32'h800);
      sample(); advance();
    end
    set_if(32'h400, 1'b1, 1'b0);
    set_id(1'b1, 1'b1, 32'h414, 1'b0, 1'b1, 1'b1, 32'h800);
    sample();
    chk("pre_rst_taken", 32'(bus.pred_taken_if), 32'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    model_eval();
    check_outputs();
    chk("in_rst_target", bus.pred_target_if, 32'h404);
    @(posedge clk); #1;
    rst = 1'b0;
    set_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int j = 0; j < 6; j++) begin
      set_if(32'h400 + 32'(4 * j), 1'b0, 1'b0);
      sample();
      chk("post_rst_not_taken", 32'(bus.pred_taken_if), 32'h0);
      advance();
    end
    chk("post_rst_ctrl_cnt", bus.ctrl_cnt, 32'h0);
    chk("post_rst_miss_cnt", bus.miss_cnt, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
